// File: rtl/badge_led_engine_if.sv
// Command byte channel from the UART receiver into the LED engine.
interface badge_led_engine_if;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/badge_led_engine.sv
// Badge LED engine: rotating pattern, PWM dimming, per-cat alive mask and a
// single-byte command decoder.
module badge_led_engine #(
  parameter int               N_LED        = 8,
  parameter int               PWM_BITS     = 3,
  parameter int               DUTY_INIT    = 1,
  parameter int               ROT_PERIOD   = 2_400_000,
  parameter logic [N_LED-1:0] PATTERN_INIT = 'b101
) (
  input  logic                 clk,
  input  logic                 reset,
  badge_led_engine_if.slave    rx,
  output logic [N_LED-1:0]     led,
  output logic [N_LED-1:0]     cat_status,
  output logic [PWM_BITS:0]    duty,
  output logic                 paused,
  output logic                 cmd_err
);

  localparam int                RW       = (ROT_PERIOD > 2) ? $clog2(ROT_PERIOD) : 1;
  localparam logic [RW-1:0]     ROT_LAST = RW'(ROT_PERIOD - 1);
  localparam int                DMAX_I   = 1 << PWM_BITS;
  localparam logic [PWM_BITS:0] DUTY_MAX = DMAX_I[PWM_BITS:0];
  localparam logic [PWM_BITS:0] DUTY_RST = DUTY_INIT[PWM_BITS:0];

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [RW-1:0]       rot_cnt;
  logic [N_LED-1:0]    pattern;
  logic                dir;

  logic                pwm_on, rot_tick;
  logic [N_LED-1:0]    rot_l, rot_r;
  logic [N_LED-1:0]    kill_hit, revive_hit, cat_next;
  logic                is_inc, is_dec, is_tog, is_left, is_right, is_all, is_bad;

  assign pwm_on   = ({1'b0, pwm_cnt} < duty);
  assign rot_tick = !paused && (rot_cnt == ROT_LAST);

  if (N_LED == 1) begin : g_rot1
    assign rot_l = pattern;
    assign rot_r = pattern;
  end else begin : g_rotn
    assign rot_l = {pattern[N_LED-2:0], pattern[N_LED-1]};
    assign rot_r = {pattern[0], pattern[N_LED-1:1]};
  end

  // Per-lane decode: 'A'+i kills cat i, 'a'+i revives it; '!' revives all.
  for (genvar i = 0; i < N_LED; i++) begin : g_lane
    localparam logic [7:0] KILL_CH   = 8'(65 + i);
    localparam logic [7:0] REVIVE_CH = 8'(97 + i);
    assign kill_hit[i]   = rx.rx_valid && (rx.rx_data == KILL_CH);
    assign revive_hit[i] = rx.rx_valid && (rx.rx_data == REVIVE_CH);
    assign cat_next[i]   = is_all | revive_hit[i] | (cat_status[i] & ~kill_hit[i]);
  end

  always_comb begin
    is_inc   = rx.rx_valid && (rx.rx_data == 8'h2B);
    is_dec   = rx.rx_valid && (rx.rx_data == 8'h2D);
    is_tog   = rx.rx_valid && (rx.rx_data == 8'h2E);
    is_left  = rx.rx_valid && (rx.rx_data == 8'h3C);
    is_right = rx.rx_valid && (rx.rx_data == 8'h3E);
    is_all   = rx.rx_valid && (rx.rx_data == 8'h21);
    is_bad   = rx.rx_valid && !(|kill_hit || |revive_hit || is_inc || is_dec ||
                                is_tog || is_left || is_right || is_all);
  end

  // Tick and command are applied independently on the same edge; a pause
  // toggle only gates rotation from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt    <= '0;
      rot_cnt    <= '0;
      pattern    <= PATTERN_INIT;
      cat_status <= '1;
      duty       <= DUTY_RST;
      paused     <= 1'b0;
      dir        <= 1'b0;
      cmd_err    <= 1'b0;
      led        <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (!paused) rot_cnt <= rot_tick ? '0 : rot_cnt + 1'b1;
      if (rot_tick) pattern <= dir ? rot_r : rot_l;
      cat_status <= cat_next;
      if (is_inc && duty != DUTY_MAX) duty <= duty + 1'b1;
      if (is_dec && duty != '0)       duty <= duty - 1'b1;
      if (is_tog)   paused <= ~paused;
      if (is_left)  dir    <= 1'b0;
      if (is_right) dir    <= 1'b1;
      cmd_err <= is_bad;
      // Dead cats stay lit regardless of pattern or PWM phase.
      led <= (pattern & cat_status & {N_LED{pwm_on}}) | ~cat_status;
    end
  end

endmodule

// File: doc/badge_led_engine.md
BADGE_LED_ENGINE -- requirements
Module: badge_led_engine

Interface
REQ-001 SHALL have parameter N_LED, default 8, number of LED/cat channels (legal 1..26).
REQ-002 SHALL have parameter PWM_BITS, default 3, width of the PWM phase counter.
REQ-003 SHALL have parameter DUTY_INIT, default 1, duty value loaded at reset (0..2^PWM_BITS).
REQ-004 SHALL have parameter ROT_PERIOD, default 2_400_000, clock cycles per pattern rotation step (>=2).
REQ-005 SHALL have parameter PATTERN_INIT, default 'b101 (zero-extended to N_LED), pattern loaded at reset.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data holds a received byte.
REQ-009 SHALL have port rx_data  input  8  command byte, sampled only when rx_valid=1.
REQ-010 SHALL have port led  output  N_LED  registered LED drive, 1 = lit.
REQ-011 SHALL have port cat_status  output  N_LED  alive mask, 1 = alive.
REQ-012 SHALL have port duty  output  PWM_BITS+1  current duty value.
REQ-013 SHALL have port paused  output  1  1 = rotation frozen.
REQ-014 SHALL have port cmd_err  output  1  one-cycle pulse on an unrecognised byte.

Function
REQ-015 SHALL run pwm_cnt 0..2^PWM_BITS-1, +1 every cycle, wrapping to 0; pwm_on = (pwm_cnt < duty), so duty 0 = never on and duty 2^PWM_BITS = always on.
REQ-016 SHALL run rot_cnt 0..ROT_PERIOD-1 while paused=0; tick when rot_cnt = ROT_PERIOD-1, then rot_cnt wraps to 0 on the same edge.
REQ-017 SHALL, on tick, rotate pattern by one position: left (bit N_LED-1 wraps into bit 0) when dir=0, right (bit 0 wraps into bit N_LED-1) when dir=1.
REQ-018 SHALL hold rot_cnt and pattern unchanged while paused=1; on unpause, counting resumes from the held value.
REQ-019 SHALL decode bytes with rx_valid=1 as: 'A'+i (i<N_LED) clears cat_status[i]; 'a'+i sets cat_status[i]; '+' duty+1, saturating at 2^PWM_BITS; '-' duty-1, saturating at 0; '.' toggles paused; '<' sets dir=0; '>' sets dir=1; '!' sets cat_status to all ones.
REQ-020 SHALL treat any other byte, including 'A'+i or 'a'+i with i>=N_LED, as unrecognised: no state change, and cmd_err=1 for exactly the next cycle.
REQ-021 SHALL ignore rx_data while rx_valid=0; cmd_err SHALL be 0 in that case.
REQ-022 SHALL make command effects visible on cat_status, duty and paused on the edge that samples rx_valid=1 (zero added latency).
REQ-023 SHALL register led = (pattern & cat_status & {N_LED{pwm_on}}) | ~cat_status, with one cycle latency from those terms; dead cats are therefore lit steadily.
REQ-024 SHALL apply a rotation tick and a command on the same edge independently; a '.' arriving on a tick edge SHALL still allow that tick, and pause applies from the next cycle.
REQ-025 SHALL leave a saturating '+' or '-' as a no-op without raising cmd_err.

Reset
REQ-026 SHALL, while reset=1 and independent of clk, force pwm_cnt=0, rot_cnt=0, pattern=PATTERN_INIT, cat_status=all ones, duty=DUTY_INIT, paused=0, dir=0, cmd_err=0, led=0.
REQ-027 SHALL, when reset asserts mid-operation (including on a tick or command cycle), discard all pending effects; the first rising edge after deassertion SHALL behave as cycle 0.

Verification
REQ-028 SHALL verify: defaults, ROT_PERIOD=4; observe pattern after reset -> 'b101, then 'b1010 after 4 cycles, 'b10100 after 8; led follows one cycle later, gated by pwm_on.
REQ-029 SHALL verify: send 'C' then 'c' -> cat_status[2] reads 0 on the sampling edge, led[2]=1 steadily one cycle later; after 'c', cat_status[2]=1.
REQ-030 SHALL verify: PWM_BITS=3; send '+' x10 -> duty saturates at 8 and led equals pattern&alive continuously; send '-' x10 -> duty=0 and alive LEDs stay dark; cmd_err stays 0 throughout.
REQ-031 SHALL verify: send '.' -> paused=1 and pattern frozen for 3*ROT_PERIOD cycles; send '.' again -> first tick arrives after the remaining rot_cnt count; then '>' -> the next tick rotates right.
REQ-032 SHALL verify: N_LED=8; send 'I', 'z', 0x00 -> each raises cmd_err for exactly one cycle and leaves cat_status, duty and pattern unchanged.
REQ-033 SHALL verify: assert reset asynchronously mid-period after 'A' and '+' -> all outputs return immediately to their REQ-026 values, and the rotation restarts a full ROT_PERIOD after deassertion.
